// File: rtl/frame_ram_pkg.sv
// rtl/frame_ram_pkg.sv - shared widths, arbiter state encoding and pixel packing
package frame_ram_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ACK  = 2'd1,
        RD_DATA = 2'd2,
        WR_ACK  = 2'd3
    } arb_state_t;

    function automatic logic [23:0] pack_rgb(input logic [7:0] red,
                                             input logic [7:0] green,
                                             input logic [7:0] blue);
        return {red, green, blue};
    endfunction

endpackage

// File: rtl/wr_cmd_fifo.sv
// rtl/wr_cmd_fifo.sv - write-command FIFO; a push on a full FIFO is taken when a pop frees the slot
module wr_cmd_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/frame_ram_arbiter.sv
// rtl/frame_ram_arbiter.sv - frame-RAM port shared by queued pixel writes and prioritised scan-out reads
module frame_ram_arbiter
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int WFIFO_DEPTH   = 4,
    parameter int MAX_RD_STREAK = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_strobe,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pending,
    output logic              wr_overflow,
    input  logic              ovf_clr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_grant,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

    arb_state_t                 state;
    arb_state_t                 state_next;
    logic [STREAK_W-1:0]        streak;
    logic                       do_read;
    logic                       do_write;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ADDR_W+DATA_W-1:0]   fifo_dout;
    logic                       ovf_set;

    wr_cmd_fifo #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(WFIFO_DEPTH)
    ) u_wr_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_strobe),
        .pop   (do_write),
        .din   ({wr_addr, wr_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A strobe on a full FIFO survives only if this edge pops the head.
    assign ovf_set    = wr_strobe && fifo_full && !do_write;
    assign wr_pending = !fifo_empty || (state == WR_ACK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_read    = 1'b0;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req && (fifo_empty || streak < STREAK_MAX)) begin
                    do_read    = 1'b1;
                    state_next = RD_ACK;
                end else if (!fifo_empty) begin
                    do_write   = 1'b1;
                    state_next = WR_ACK;
                end
            end
            RD_ACK:  if (mem_ack)    state_next = RD_DATA;
            RD_DATA: if (mem_rvalid) state_next = IDLE;
            WR_ACK:  if (mem_ack)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rd_grant    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            streak      <= '0;
            wr_overflow <= 1'b0;
        end else begin
            rd_grant <= (state == RD_ACK) && mem_ack;
            rd_valid <= (state == RD_DATA) && mem_rvalid;
            if ((state == RD_DATA) && mem_rvalid) begin
                rd_data <= mem_rdata;
            end

            if (do_read) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= rd_addr;
                mem_wdata <= '0;
            end else if (do_write) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= fifo_dout[ADDR_W+DATA_W-1:DATA_W];
                mem_wdata <= fifo_dout[DATA_W-1:0];
            end else if (((state == RD_ACK) || (state == WR_ACK)) && mem_ack) begin
                mem_req <= 1'b0;
            end

            // Streak only measures how long a queued write has been held off.
            if (fifo_empty || do_write) begin
                streak <= '0;
            end else if (do_read && (streak < STREAK_MAX)) begin
                streak <= streak + STREAK_W'(1);
            end

            if (ovf_set) begin
                wr_overflow <= 1'b1;
            end else if (ovf_clr) begin
                wr_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// tb/tb_frame_ram_arbiter.sv - directed scoreboard bench for frame_ram_arbiter
module tb_frame_ram_arbiter;
    import frame_ram_pkg::*;

    localparam int AW = 26;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_strobe = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_pending;
    logic          wr_overflow;
    logic          ovf_clr = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_grant;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata = '0;

    logic auto_mode  = 1'b0;
    logic man_ack    = 1'b0;
    logic man_rvalid = 1'b0;

    // Auto mode models a RAM that acks immediately and returns data right after the grant.
    assign mem_ack    = auto_mode ? mem_req  : man_ack;
    assign mem_rvalid = auto_mode ? rd_grant : man_rvalid;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [63:0] cmd_q [$];
    logic [63:0] rd_q  [$];
    logic        prev_req = 1'b0;

    always #5 clk = ~clk;

    frame_ram_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_pending  (wr_pending),
        .wr_overflow (wr_overflow),
        .ovf_clr     (ovf_clr),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_grant    (rd_grant),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cmd_word(input logic we, input logic [AW-1:0] a,
                                             input logic [DW-1:0] d);
        return {13'b0, we, a, (we ? d : {DW{1'b0}})};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((cmd_q.size() != 0 || rd_q.size() != 0 || mem_req || wr_pending) && n < 300) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 64'(n < 300), 64'(1));
    endtask

    // Scoreboard: every new command and every returned pixel is matched in order.
    always @(negedge clk) begin
        logic [63:0] e;
        if (mem_req && !prev_req) begin
            if (cmd_q.size() == 0) begin
                check("cmd_q_underflow", 64'(cmd_q.size()), 64'(1));
            end else begin
                e = cmd_q.pop_front();
                check("mem_cmd", cmd_word(mem_we, mem_addr, mem_wdata), e);
            end
        end
        prev_req = mem_req;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                check("rd_q_underflow", 64'(rd_q.size()), 64'(1));
            end else begin
                e = rd_q.pop_front();
                check("rd_data", 64'(rd_data), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (2) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rd_grant", rd_grant, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wr_pending", wr_pending, 0);
        check("rst_wr_overflow", wr_overflow, 0);
        reset = 1'b0;
        step();

        // Single write, acked after 3 cycles
        wr_strobe = 1'b1;
        wr_addr   = 26'h000123;
        wr_data   = pack_rgb(8'hFF, 8'h80, 8'h40);
        cmd_q.push_back(cmd_word(1'b1, 26'h000123, 24'hFF8040));
        step();
        wr_strobe = 1'b0;
        check("wr_pending_queued", wr_pending, 1);
        check("wr_req_not_yet", mem_req, 0);
        step();
        check("wr_mem_req", mem_req, 1);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 64'h000123);
        check("wr_mem_wdata", mem_wdata, 64'hFF8040);
        repeat (2) step();
        check("wr_req_held", mem_req, 1);
        check("wr_pending_in_flight", wr_pending, 1);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("wr_req_dropped", mem_req, 0);
        check("wr_pending_clear", wr_pending, 0);

        // Single read: ack after 2 cycles, data 4 cycles later
        rd_req  = 1'b1;
        rd_addr = 26'h0000AA;
        cmd_q.push_back(cmd_word(1'b0, 26'h0000AA, '0));
        rd_q.push_back(64'h123456);
        step();
        check("rd_mem_req", mem_req, 1);
        check("rd_mem_we", mem_we, 0);
        check("rd_no_early_grant", rd_grant, 0);
        step();
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        check("rd_grant_pulse", rd_grant, 1);
        check("rd_req_dropped", mem_req, 0);
        rd_req = 1'b0;
        step();
        check("rd_grant_one_cycle", rd_grant, 0);
        repeat (3) step();
        man_rvalid = 1'b1;
        mem_rdata  = 24'h123456;
        step();
        man_rvalid = 1'b0;
        check("rd_valid_pulse", rd_valid, 1);
        check("rd_data_value", rd_data, 64'h123456);
        step();
        check("rd_valid_one_cycle", rd_valid, 0);

        // Starvation guard: 8 reads, then the queued write, then reads resume
        rd_addr = 26'h000200;
        rd_req  = 1'b1;
        mem_rdata = 24'h5A5A5A;
        cmd_q.push_back(cmd_word(1'b0, 26'h000200, '0));
        rd_q.push_back(64'h5A5A5A);
        step();
        wr_strobe = 1'b1;
        wr_addr   = 26'h3FF0000;
        wr_data   = 24'hC0FFEE;
        step();
        wr_strobe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back(cmd_word(1'b0, 26'h000200, '0));
            rd_q.push_back(64'h5A5A5A);
        end
        cmd_q.push_back(cmd_word(1'b1, 26'h3FF0000, 24'hC0FFEE));
        for (int i = 0; i < 2; i++) begin
            cmd_q.push_back(cmd_word(1'b0, 26'h000200, '0));
            rd_q.push_back(64'h5A5A5A);
        end
        auto_mode = 1'b1;
        n = 0;
        while (cmd_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check("starve_all_cmds_seen", 64'(cmd_q.size()), 64'(0));
        rd_req = 1'b0;
        drain("starve");
        auto_mode = 1'b0;

        // Overflow: six back-to-back strobes with no ack, sixth is dropped
        for (int i = 0; i < 6; i++) begin
            wr_strobe = 1'b1;
            wr_addr   = 26'h001000 + AW'(i);
            wr_data   = pack_rgb(8'h10 + 8'(i), 8'h20, 8'h30);
            if (i < 5) cmd_q.push_back(cmd_word(1'b1, 26'h001000 + AW'(i),
                                               pack_rgb(8'h10 + 8'(i), 8'h20, 8'h30)));
            step();
            if (i == 4) check("ovf_not_yet", wr_overflow, 0);
        end
        check("ovf_set", wr_overflow, 1);
        check("ovf_head_held", mem_addr, 64'h001000);
        wr_addr = 26'h001006;
        ovf_clr = 1'b1;
        step();
        check("ovf_wins_over_clr", wr_overflow, 1);
        wr_strobe = 1'b0;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", wr_overflow, 0);
        auto_mode = 1'b1;
        drain("ovf");
        auto_mode = 1'b0;

        // Full FIFO plus a strobe on the pop decision edge
        rd_req  = 1'b1;
        rd_addr = 26'h000300;
        cmd_q.push_back(cmd_word(1'b0, 26'h000300, '0));
        step();
        for (int i = 0; i < 4; i++) begin
            wr_strobe = 1'b1;
            wr_addr   = 26'h002000 + AW'(i);
            wr_data   = 24'hAB0000 + DW'(i);
            cmd_q.push_back(cmd_word(1'b1, 26'h002000 + AW'(i), 24'hAB0000 + DW'(i)));
            step();
        end
        wr_strobe = 1'b0;
        check("full_no_ovf", wr_overflow, 0);
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        rd_req  = 1'b0;
        man_rvalid = 1'b1;
        mem_rdata  = 24'h0F0F0F;
        rd_q.push_back(64'h0F0F0F);
        step();
        man_rvalid = 1'b0;
        wr_strobe = 1'b1;
        wr_addr   = 26'h002004;
        wr_data   = 24'hAB0004;
        cmd_q.push_back(cmd_word(1'b1, 26'h002004, 24'hAB0004));
        step();
        wr_strobe = 1'b0;
        check("full_pop_strobe_no_ovf", wr_overflow, 0);
        check("full_pop_head_addr", mem_addr, 64'h002000);
        auto_mode = 1'b1;
        drain("full_pop");
        auto_mode = 1'b0;

        // Reset while waiting in RD_DATA
        rd_req  = 1'b1;
        rd_addr = 26'h000044;
        cmd_q.push_back(cmd_word(1'b0, 26'h000044, '0));
        step();
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        rd_req  = 1'b0;
        check("rst_mid_grant", rd_grant, 1);
        reset = 1'b1;
        #1;
        check("rst_async_grant", rd_grant, 0);
        check("rst_async_req", mem_req, 0);
        step();
        reset = 1'b0;
        step();
        man_rvalid = 1'b1;
        mem_rdata  = 24'h777777;
        step();
        man_rvalid = 1'b0;
        check("rst_late_rvalid_ignored", rd_valid, 0);
        check("rst_mem_req_idle", mem_req, 0);
        check("rst_state_idle", 64'(dut.state), 64'(IDLE));

        // Normal read after reset
        rd_req  = 1'b1;
        rd_addr = 26'h000055;
        auto_mode = 1'b1;
        cmd_q.push_back(cmd_word(1'b0, 26'h000055, '0));
        rd_q.push_back(64'h777777);
        step();
        step();
        check("post_rst_grant", rd_grant, 1);
        rd_req = 1'b0;
        drain("post_rst");
        auto_mode = 1'b0;

        check("cmd_q_empty", 64'(cmd_q.size()), 64'(0));
        check("rd_q_empty", 64'(rd_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
